acia_tx_sched: RTL and testbench

//  Shares the ACIA transmitter between NREQ hardware byte sources (e.g. CPU shim, debug

---
 rtl/acia_sched_pkg.sv | 31 +++
 rtl/acia_rr_arb.sv | 31 +++
 rtl/acia_tx_sched.sv | 152 +++++++++++++++
 tb/tb_acia_tx_sched.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/acia_sched_pkg.sv
// Shared encodings for the ACIA transmit scheduler: FSM states, ACIA status bits,
// control words and register-select values.
package acia_sched_pkg;

    localparam logic [2:0] ST_RST_WR  = 3'd0;
    localparam logic [2:0] ST_CFG_WR  = 3'd1;
    localparam logic [2:0] ST_IDLE    = 3'd2;
    localparam logic [2:0] ST_RD_ST   = 3'd3;
    localparam logic [2:0] ST_WT_ST   = 3'd4;
    localparam logic [2:0] ST_CHK     = 3'd5;
    localparam logic [2:0] ST_WR_DAT  = 3'd6;

    typedef enum logic [2:0] {
        RST_WR = ST_RST_WR,
        CFG_WR = ST_CFG_WR,
        IDLE   = ST_IDLE,
        RD_ST  = ST_RD_ST,
        WT_ST  = ST_WT_ST,
        CHK    = ST_CHK,
        WR_DAT = ST_WR_DAT
    } sched_state_t;

    localparam int         ACIA_ST_TXE    = 1;
    localparam int         ACIA_ST_RXF    = 0;
    localparam logic [7:0] ACIA_CTRL_MRST = 8'h03;
    localparam logic       RS_CTRL        = 1'b0;
    localparam logic       RS_DATA        = 1'b1;
    localparam logic [7:0] ASCII_LF       = 8'h0A;
    localparam logic [7:0] ASCII_CR       = 8'h0D;

endpackage

// File: rtl/acia_rr_arb.sv
// Combinational round-robin picker: first valid requester at or after the pointer,
// returned both as a one-hot vector and as a 3-bit index.
module acia_rr_arb #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [2:0]      ptr,
    output logic [NREQ-1:0] onehot,
    output logic [2:0]      idx,
    output logic            any
);

    int j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!any && valid[j]) begin
                any       = 1'b1;
                onehot[j] = 1'b1;
                idx       = 3'(j);
            end
        end
    end

endmodule

// File: rtl/acia_tx_sched.sv
// Shares one ACIA transmitter between NREQ byte sources: initialises the ACIA, then
// arbitrates round-robin, polls TXE and writes data. Option: ACIA_SCHED_CRLF_EN (LF -> CR LF).
module acia_tx_sched
    import acia_sched_pkg::*;
#(
    parameter int         NREQ     = 2,
    parameter logic [7:0] CTRL_CFG = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              acia_cs,
    output logic              acia_we,
    output logic              acia_rs,
    output logic [7:0]        acia_din,
    input  logic [7:0]        acia_dout,
    output logic              init_done,
    output logic [2:0]        grant_id
);

    localparam logic [2:0] LAST_IDX = 3'(NREQ - 1);

    sched_state_t    state_q, state_d;
    logic [2:0]      ptr_q;
    logic [NREQ-1:0] grant_oh_q;
    logic [7:0]      byte_q;
    logic [NREQ-1:0] arb_valid, arb_onehot;
    logic [2:0]      arb_idx;
    logic            arb_any;
    logic [7:0]      sel_byte, wr_byte;
    logic            wr_final;
    logic            unused_dout;

    assign unused_dout = ^{acia_dout[7:2], acia_dout[ACIA_ST_RXF]};

    // A requester whose ready pulse is visible this cycle still shows its old valid;
    // it must not be granted again on that stale request.
    assign arb_valid = req_valid & ~req_ready;

    acia_rr_arb #(.NREQ(NREQ)) u_arb (
        .valid  (arb_valid),
        .ptr    (ptr_q),
        .onehot (arb_onehot),
        .idx    (arb_idx),
        .any    (arb_any)
    );

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_onehot[i]) sel_byte = req_data[8*i +: 8];
        end
    end

`ifdef ACIA_SCHED_CRLF_EN
    logic crlf_q;
    logic expand;

    assign expand   = (byte_q == ASCII_LF) && !crlf_q;
    assign wr_byte  = expand ? ASCII_CR : byte_q;
    assign wr_final = !expand;
`else
    assign wr_byte  = byte_q;
    assign wr_final = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            RST_WR: state_d = CFG_WR;
            CFG_WR: state_d = IDLE;
            IDLE:   if (arb_any) state_d = RD_ST;
            RD_ST:  state_d = WT_ST;
            WT_ST:  state_d = CHK;
            CHK:    state_d = acia_dout[ACIA_ST_TXE] ? WR_DAT : RD_ST;
            WR_DAT: state_d = wr_final ? IDLE : RD_ST;
            default: state_d = RST_WR;
        endcase
    end

    // Bus outputs are registered from the current state, so each access appears
    // on the bus one cycle after its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RST_WR;
            ptr_q      <= '0;
            grant_id   <= '0;
            grant_oh_q <= '0;
            init_done  <= 1'b0;
            req_ready  <= '0;
            acia_cs    <= 1'b0;
            acia_we    <= 1'b0;
            acia_rs    <= 1'b0;
            acia_din   <= '0;
`ifdef ACIA_SCHED_CRLF_EN
            crlf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            acia_cs   <= 1'b0;
            acia_we   <= 1'b0;
            req_ready <= '0;
            case (state_q)
                RST_WR: begin
                    acia_cs  <= 1'b1;
                    acia_we  <= 1'b1;
                    acia_rs  <= RS_CTRL;
                    acia_din <= ACIA_CTRL_MRST;
                end
                CFG_WR: begin
                    acia_cs   <= 1'b1;
                    acia_we   <= 1'b1;
                    acia_rs   <= RS_CTRL;
                    acia_din  <= CTRL_CFG;
                    init_done <= 1'b1;
                end
                IDLE: begin
                    if (arb_any) begin
                        grant_id   <= arb_idx;
                        grant_oh_q <= arb_onehot;
                    end
                end
                RD_ST: begin
                    acia_cs <= 1'b1;
                    acia_we <= 1'b0;
                    acia_rs <= RS_CTRL;
                end
                WR_DAT: begin
                    acia_cs  <= 1'b1;
                    acia_we  <= 1'b1;
                    acia_rs  <= RS_DATA;
                    acia_din <= wr_byte;
`ifdef ACIA_SCHED_CRLF_EN
                    crlf_q   <= expand;
`endif
                    if (wr_final) begin
                        req_ready <= grant_oh_q;
                        ptr_q     <= (grant_id == LAST_IDX) ? 3'd0 : grant_id + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && arb_any) byte_q <= sel_byte;
    end

endmodule

// File: tb/tb_acia_tx_sched.sv
// Self-checking bench for acia_tx_sched: ACIA model, expected-write scoreboard and
// directed scenarios (init, single byte, rotation, TXE stall, LF expansion, reset abort).
module tb_acia_tx_sched;

    localparam int NREQ = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  req_ready;
    logic        acia_cs, acia_we, acia_rs;
    logic [7:0]  acia_din;
    logic [7:0]  acia_dout = '0;
    logic        init_done;
    logic [2:0]  grant_id;

    acia_tx_sched #(.NREQ(NREQ), .CTRL_CFG(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .acia_cs   (acia_cs),
        .acia_we   (acia_we),
        .acia_rs   (acia_rs),
        .acia_din  (acia_din),
        .acia_dout (acia_dout),
        .init_done (init_done),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    // ACIA model: status read returns TXE in bit 1 one cycle later; TXE drops for
    // two cycles after each data write, and is forced low until txe_off_until.
    int   mcyc = 0;
    int   busy = 0;
    int   txe_off_until = 0;
    logic txe_ok = 1'b0;
    logic txe_now;

    assign txe_now = (busy == 0) && (mcyc >= txe_off_until);

    always @(posedge clk) begin
        mcyc <= mcyc + 1;
        if (busy > 0) busy <= busy - 1;
        if (acia_cs && !acia_we) begin
            acia_dout <= {6'b0, txe_now, 1'b0};
            if (txe_now) txe_ok <= 1'b1;
        end
        if (acia_cs && acia_we && acia_rs) begin
            busy   <= 2;
            txe_ok <= 1'b0;
        end
        if (!rst_n) txe_ok <= 1'b0;
    end

    typedef struct packed {
        logic       rs;
        logic [7:0] din;
        logic [1:0] rdy;
        logic [2:0] gid;
    } wr_t;

    wr_t  exp_q[$];
    int   n_chk = 0, n_fail = 0, n_writes = 0, n_reads = 0;
    int   src_left[2] = '{0, 0};
    int   ready_cnt[2] = '{0, 0};
    int   ptr_m = 0;
    logic data_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic rs, input logic [7:0] d, input logic [1:0] r,
                           input logic [2:0] g);
        wr_t e;
        e.rs = rs; e.din = d; e.rdy = r; e.gid = g;
        exp_q.push_back(e);
    endtask

    function automatic int rr_pick(input logic [1:0] v, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (v[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic compare();
        wr_t e;
        if (acia_cs && acia_we) begin
            n_writes++;
            if (acia_rs) data_seen = 1'b1;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL spurious_write: got rs=%0d din=%0h, expected no write", acia_rs, acia_din);
            end else begin
                e = exp_q.pop_front();
                check("wr_rs", 32'(acia_rs), 32'(e.rs));
                check("wr_din", 32'(acia_din), 32'(e.din));
                check("wr_ready", 32'(req_ready), 32'(e.rdy));
                if (e.rs) begin
                    check("wr_grant", 32'(grant_id), 32'(e.gid));
                    check("wr_after_txe", 32'(txe_ok), 32'd1);
                end
            end
        end else begin
            check("ready_without_write", 32'(req_ready), 32'd0);
        end
        if (acia_cs && !acia_we) begin
            n_reads++;
            check("read_rs", 32'(acia_rs), 32'd0);
        end
    endtask

    task automatic step();
        @(negedge clk);
        data_seen = 1'b0;
        if (rst_n) compare();
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                ready_cnt[i]++;
                if (src_left[i] > 0) src_left[i]--;
                if (src_left[i] == 0) req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_data_write(output int k);
        k = 0;
        data_seen = 1'b0;
        while (!data_seen && k < 60) begin
            step();
            k++;
        end
        if (!data_seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL data_write_timeout: got no write in %0d cycles, expected one", k);
        end
    endtask

    initial begin
        int k, r0, w0, c0, c1, p;
        logic [1:0] vm;
        int left[2];

        // 1: init sequence, then an idle bus
        repeat (3) @(negedge clk);
        push_wr(1'b0, 8'h03, 2'b00, 3'd0);
        push_wr(1'b0, 8'h00, 2'b00, 3'd0);
        rst_n = 1'b1;
        repeat (10) step();
        check("init_writes", 32'(n_writes), 32'd2);
        check("init_queue_drained", 32'(exp_q.size()), 32'd0);
        check("init_done", 32'(init_done), 32'd1);
        check("init_no_reads", 32'(n_reads), 32'd0);
        repeat (20) step();
        check("idle_bus", 32'(n_writes), 32'd2);

        // 2: single byte, latency 5 cycles, one status read
        p = rr_pick(2'b01, ptr_m);
        push_wr(1'b1, 8'h41, 2'b01, 3'(p));
        ptr_m = (p + 1) % NREQ;
        r0 = n_reads;
        req_data[7:0] = 8'h41; src_left[0] = 1; req_valid[0] = 1'b1;
        wait_data_write(k);
        check("single_latency", 32'(k), 32'd5);
        check("single_reads", 32'(n_reads - r0), 32'd1);
        check("model_ptr_after_single", 32'(ptr_m), 32'd1);
        repeat (5) step();

        // 3: both requesters, four bytes each, strict rotation
        left[0] = 4; left[1] = 4;
        for (int n = 0; n < 8; n++) begin
            vm = {left[1] > 0, left[0] > 0};
            p = rr_pick(vm, ptr_m);
            push_wr(1'b1, (p == 0) ? 8'h11 : 8'h22, 2'(1 << p), 3'(p));
            left[p]--;
            ptr_m = (p + 1) % NREQ;
        end
        check("model_first_rr", 32'(exp_q[0].din), 32'h22);
        c0 = ready_cnt[0]; c1 = ready_cnt[1];
        req_data = {8'h22, 8'h11}; src_left[0] = 4; src_left[1] = 4; req_valid = 2'b11;
        for (int n = 0; n < 8; n++) wait_data_write(k);
        check("rr_ready0", 32'(ready_cnt[0] - c0), 32'd4);
        check("rr_ready1", 32'(ready_cnt[1] - c1), 32'd4);
        repeat (5) step();

        // 4: TXE held low for 10 cycles -> repoll every 3 cycles, then one write
        p = rr_pick(2'b01, ptr_m);
        push_wr(1'b1, 8'h55, 2'b01, 3'(p));
        ptr_m = (p + 1) % NREQ;
        r0 = n_reads; w0 = n_writes;
        txe_off_until = mcyc + 10;
        req_data[7:0] = 8'h55; src_left[0] = 1; req_valid[0] = 1'b1;
        wait_data_write(k);
        check("stall_latency", 32'(k), 32'd14);
        check("stall_reads", 32'(n_reads - r0), 32'd4);
        check("stall_single_write", 32'(n_writes - w0), 32'd1);
        repeat (5) step();

        // 5: LF byte
        p = rr_pick(2'b01, ptr_m);
`ifdef ACIA_SCHED_CRLF_EN
        push_wr(1'b1, 8'h0D, 2'b00, 3'(p));
`endif
        push_wr(1'b1, 8'h0A, 2'b01, 3'(p));
        ptr_m = (p + 1) % NREQ;
        c0 = ready_cnt[0]; w0 = n_writes;
        req_data[7:0] = 8'h0A; src_left[0] = 1; req_valid[0] = 1'b1;
        wait_data_write(k);
`ifdef ACIA_SCHED_CRLF_EN
        wait_data_write(k);
`endif
        repeat (5) step();
        check("lf_one_ready", 32'(ready_cnt[0] - c0), 32'd1);
`ifdef ACIA_SCHED_CRLF_EN
        check("lf_write_count", 32'(n_writes - w0), 32'd2);
`else
        check("lf_write_count", 32'(n_writes - w0), 32'd1);
`endif

        // 6: reset while waiting for status, then re-init and serve the pending byte
        r0 = n_reads;
        req_data[15:8] = 8'h77; src_left[1] = 1; req_valid[1] = 1'b1;
        k = 0;
        while (n_reads == r0 && k < 30) begin
            step();
            k++;
        end
        check("abort_read_seen", 32'(n_reads - r0), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("abort_outputs_zero",
                 32'({acia_cs, acia_we, acia_rs, acia_din, req_ready, init_done, grant_id}), 32'd0);
        exp_q.delete();
        ptr_m = 0;
        push_wr(1'b0, 8'h03, 2'b00, 3'd0);
        push_wr(1'b0, 8'h00, 2'b00, 3'd0);
        p = rr_pick(2'b10, ptr_m);
        push_wr(1'b1, 8'h77, 2'(1 << p), 3'(p));
        ptr_m = (p + 1) % NREQ;
        c1 = ready_cnt[1];
        for (int n = 0; n < 3; n++) begin
            step();
            check("ready_in_reset", 32'(req_ready), 32'd0);
        end
        w0 = n_writes;
        rst_n = 1'b1;
        wait_data_write(k);
        check("reinit_write_count", 32'(n_writes - w0), 32'd3);
        check("reinit_done", 32'(init_done), 32'd1);
        check("pending_ready_once", 32'(ready_cnt[1] - c1), 32'd1);
        repeat (5) step();
        check("final_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
